// File: rtl/offset_sign_serial_if.sv
// Handshake and data bundle for the bit-serial sign-dependent offset converter.
// The master drives start/x and the slave (the converter) returns busy/done/y.
interface offset_sign_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   y;

  modport master (output start, output x, input busy, input done, input y);
  modport slave  (input start, input x, output busy, output done, output y);
endinterface

// File: rtl/offset_sign_serial.sv
// Bit-serial sign-dependent offset converter.
// y = x + POS_OFF for x >= 0, y = x - NEG_OFF for x < 0, computed LSB-first
// through one full adder and a carry flop. The result is WIDTH+1 bits wide, so
// the legal offset ranges can never overflow it.
module offset_sign_serial #(
  parameter int WIDTH   = 4,
  parameter int POS_OFF = 3,
  parameter int NEG_OFF = 2
) (
  input  logic                clk,
  input  logic                rst,
  offset_sign_serial_if.slave bus
);

  localparam int     W1      = WIDTH + 1;
  localparam int     CW      = $clog2(WIDTH + 1);
  localparam longint MAX_OFF = longint'(1) << (WIDTH - 1);

  // Reject illegal configurations at elaboration instead of truncating.
  if (WIDTH < 2) begin : g_bad_width
    $error("offset_sign_serial: WIDTH must be >= 2");
  end
  if ((POS_OFF < 0) || (longint'(POS_OFF) > MAX_OFF)) begin : g_bad_pos
    $error("offset_sign_serial: POS_OFF out of range 0..2^(WIDTH-1)");
  end
  if ((NEG_OFF < 0) || (longint'(NEG_OFF) > MAX_OFF)) begin : g_bad_neg
    $error("offset_sign_serial: NEG_OFF out of range 0..2^(WIDTH-1)");
  end

  // Second operand: the positive offset, or the negated negative offset so
  // that both cases reduce to a plain addition.
  localparam logic [W1-1:0] POS_OP = W1'(POS_OFF);
  localparam logic [W1-1:0] NEG_OP = W1'(0) - W1'(NEG_OFF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W1-1:0]   xs_q, xs_d;
  logic [W1-1:0]   op_q, op_d;
  logic [W1-1:0]   res_q, res_d;
  logic [W1-1:0]   y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sum_bit;
  logic            carry_out;

  // Next-state and datapath: one full-adder step per SHIFT cycle.
  always_comb begin
    state_d   = state_q;
    xs_d      = xs_q;
    op_d      = op_q;
    res_d     = res_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sum_bit   = xs_q[0] ^ op_q[0] ^ carry_q;
    carry_out = (xs_q[0] & op_q[0]) | (xs_q[0] & carry_q) | (op_q[0] & carry_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          xs_d    = {bus.x[WIDTH-1], bus.x};
          op_d    = bus.x[WIDTH-1] ? NEG_OP : POS_OP;
          carry_d = 1'b0;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_d   = {sum_bit, res_q[W1-1:1]};
        carry_d = carry_out;
        xs_d    = xs_q >> 1;
        op_d    = op_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) begin
          // Last bit: publish the whole word at once so y never shows a partial sum.
          y_d     = {sum_bit, res_q[W1-1:1]};
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xs_q    <= {W1{1'b0}};
      op_q    <= {W1{1'b0}};
      res_q   <= {W1{1'b0}};
      y_q     <= {W1{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      op_q    <= op_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule

// File: tb/tb_offset_sign_serial.sv
// Self-checking bench for offset_sign_serial: a cycle-count behavioural model
// per instance (default 4-bit and an 8-bit/128/128 variant), compared on every
// negative edge, plus directed vectors with hand-computed expectations.
module tb_offset_sign_serial;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  logic chk_en;

  offset_sign_serial_if #(.WIDTH(4)) ifa ();
  offset_sign_serial_if #(.WIDTH(8)) ifb ();

  offset_sign_serial #(.WIDTH(4), .POS_OFF(3), .NEG_OFF(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  offset_sign_serial #(.WIDTH(8), .POS_OFF(128), .NEG_OFF(128)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ref_a(input int xv);
    return (xv >= 0) ? xv + 3 : xv - 2;
  endfunction

  function automatic int ref_b(input int xv);
    return (xv >= 0) ? xv + 128 : xv - 128;
  endfunction

  // Edge counter used for latency and spacing measurements.
  always @(posedge clk) cyc++;

  // Behavioural model: a conversion occupies WIDTH+3 cycles from accept; done
  // appears WIDTH+1 edges after accept carrying the arithmetic result.
  int ma_phase = 0, ma_x = 0, ma_y = 0;
  int mb_phase = 0, mb_x = 0, mb_y = 0;
  logic ma_done = 1'b0, mb_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ma_phase = 0; ma_done = 1'b0; ma_y = 0;
      mb_phase = 0; mb_done = 1'b0; mb_y = 0;
    end else begin
      if (ma_phase == 0) begin
        ma_done = 1'b0;
        if (ifa.start) begin ma_phase = 1; ma_x = int'($signed(ifa.x)); end
      end else if (ma_phase == 6) begin
        ma_phase = 0; ma_done = 1'b0;
      end else begin
        ma_phase++;
        if (ma_phase == 6) begin ma_done = 1'b1; ma_y = ref_a(ma_x); end
      end
      if (mb_phase == 0) begin
        mb_done = 1'b0;
        if (ifb.start) begin mb_phase = 1; mb_x = int'($signed(ifb.x)); end
      end else if (mb_phase == 10) begin
        mb_phase = 0; mb_done = 1'b0;
      end else begin
        mb_phase++;
        if (mb_phase == 10) begin mb_done = 1'b1; mb_y = ref_b(mb_x); end
      end
    end
  end

  int       a_done_total = 0, b_done_total = 0, a_busy_n = 0, b_busy_n = 0;
  logic [4:0] a_last_y;
  logic [8:0] b_last_y;
  int       a_done_q[$];
  int       b_done_q[$];

  // Compare process: DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy", ifa.busy, (ma_phase != 0));
      chk("a_done", ifa.done, ma_done);
      chk("a_y",    ifa.y,    ma_y[4:0]);
      chk("b_busy", ifb.busy, (mb_phase != 0));
      chk("b_done", ifb.done, mb_done);
      chk("b_y",    ifb.y,    mb_y[8:0]);
      if (ifa.done === 1'b1) begin a_done_total++; a_last_y = ifa.y; a_done_q.push_back(cyc); end
      if (ifb.done === 1'b1) begin b_done_total++; b_last_y = ifb.y; b_done_q.push_back(cyc); end
      if (ifa.busy === 1'b1) a_busy_n++;
      if (ifb.busy === 1'b1) b_busy_n++;
    end
  end

  task automatic run_a(input logic [3:0] xv, input logic [4:0] ey, input string nm);
    int acc, n0;
    @(negedge clk); ifa.x = xv; ifa.start = 1'b1; a_busy_n = 0; n0 = a_done_total;
    @(negedge clk); ifa.start = 1'b0; acc = cyc;
    for (int i = 0; i < 20 && a_done_total == n0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({nm, "_ndone"}, a_done_total - n0, 1);
    chk({nm, "_y"}, a_last_y, ey);
    chk({nm, "_lat"}, a_done_q[$] - acc, 5);
    chk({nm, "_busy"}, a_busy_n, 6);
  endtask

  task automatic run_b(input logic [7:0] xv, input logic [8:0] ey, input string nm);
    int acc, n0;
    @(negedge clk); ifb.x = xv; ifb.start = 1'b1; b_busy_n = 0; n0 = b_done_total;
    @(negedge clk); ifb.start = 1'b0; acc = cyc;
    for (int i = 0; i < 30 && b_done_total == n0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({nm, "_ndone"}, b_done_total - n0, 1);
    chk({nm, "_y"}, b_last_y, ey);
    chk({nm, "_lat"}, b_done_q[$] - acc, 9);
    chk({nm, "_busy"}, b_busy_n, 10);
  endtask

  initial begin
    int n0;
    checks = 0; errors = 0; cyc = 0; chk_en = 1'b0;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.x = 4'd0;
    ifb.start = 1'b0; ifb.x = 8'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_a_y", ifa.y, 5'd0);
    chk("rst_a_busy", ifa.busy, 1'b0);
    chk("rst_b_done", ifb.done, 1'b0);
    rst = 1'b0;

    // Directed 4-bit vectors.
    run_a(4'd0,    5'b00011, "a_x0");
    run_a(4'd7,    5'b01010, "a_x7");
    run_a(4'b1111, 5'b11101, "a_xm1");
    run_a(4'b1000, 5'b10110, "a_xm8");

    // Exhaustive sweep with start held high: accepts every 7 cycles.
    a_done_q.delete();
    n0 = a_done_total;
    @(negedge clk);
    ifa.start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifa.x = 4'(i - 8);
      repeat (7) @(negedge clk);
    end
    ifa.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("sweep_ndone", a_done_total - n0, 16);
    for (int i = 1; i < a_done_q.size(); i++)
      chk("sweep_spacing", a_done_q[i] - a_done_q[i-1], 7);

    // Second start during SHIFT is ignored; x changes do not leak in.
    n0 = a_done_total;
    @(negedge clk); ifa.x = 4'd5; ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    @(negedge clk); ifa.x = 4'b1010; ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("ignore_ndone", a_done_total - n0, 1);
    chk("ignore_y", a_last_y, 5'b01000);

    // Reset on the third SHIFT edge aborts the conversion.
    n0 = a_done_total;
    @(negedge clk); ifa.x = 4'b1100; ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", ifa.busy, 1'b0);
    chk("abort_done", ifa.done, 1'b0);
    chk("abort_y", ifa.y, 5'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_nodone", a_done_total - n0, 0);

    // start and rst together: reset wins.
    @(negedge clk); rst = 1'b1; ifa.start = 1'b1;
    @(negedge clk);
    chk("rststart_busy", ifa.busy, 1'b0);
    rst = 1'b0; ifa.start = 1'b0;
    @(negedge clk);
    chk("rststart_idle", ifa.busy, 1'b0);

    // 8-bit variant with maximal offsets.
    run_b(8'd127,     9'd255,        "b_x127");
    run_b(8'b10000000, 9'b100000000, "b_xm128");
    run_b(8'd0,       9'd128,        "b_x0");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/offset_sign_serial.md
Name: offset_sign_serial

Overview:
Parametrised, bit-serial successor to the 4-bit sign-dependent offset converter. For a signed WIDTH-bit input x, it produces y = x + POS_OFF when x >= 0, and y = x - NEG_OFF when x < 0, as a signed WIDTH+1-bit result. It computes LSB-first through a single full adder and a carry flip-flop under a start/done handshake. It sits in the datapath wherever the width-specific combinational converters were used and area matters more than latency.

Parameters:
WIDTH, 4, input width in bits; result is WIDTH+1 bits; must be >= 2.
POS_OFF, 3, constant added to non-negative inputs; legal range 0..2^(WIDTH-1).
NEG_OFF, 2, constant subtracted from negative inputs; legal range 0..2^(WIDTH-1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request to convert x; sampled only in IDLE.
x  input  WIDTH  signed operand; captured on the accepting edge.
busy  output  1  high from the accepting edge until the return to IDLE.
done  output  1  one-cycle pulse; y is valid.
y  output  WIDTH+1  signed result; held until the next done.

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE, y=0, done=0, busy=0, carry=0 and the bit counter to 0. Reset has priority over every other event, including start in the same cycle. Reset mid-conversion aborts it and no done pulse follows.
- Parameter check: out-of-range POS_OFF/NEG_OFF or WIDTH<2 must fail at elaboration (generate-time error). No silent truncation.
- Operand selection on accept:
  - xs = x sign-extended to WIDTH+1 bits.
  - If x[WIDTH-1]=0, op = POS_OFF as WIDTH+1 bits. x=0 counts as non-negative.
  - Otherwise, op = two's complement of NEG_OFF in WIDTH+1 bits.
  - Both xs and op are loaded into shift registers.
- Arithmetic: y = xs + op modulo 2^(WIDTH+1). The legal parameter ranges guarantee no overflow, so the result is exact.
- States:
  - IDLE: busy=0. On start=1, capture xs/op, carry=0, cnt=0, go to SHIFT. Otherwise stay.
  - SHIFT: each edge adds the LSBs of xs, op and carry. The sum bit shifts into the MSB of the result register (right shift). Carry updates, xs/op shift right, cnt increments. After WIDTH+1 shift edges (cnt = WIDTH on the last one), load y from the result register and go to DONE.
  - DONE: done=1 and busy=1 for exactly this one cycle. The next edge goes to IDLE.
- Latency: start accepted at edge k gives shift edges k+1..k+WIDTH+1. done is high in the cycle following edge k+WIDTH+1. With WIDTH=4, done goes high 5 edges after the accepting edge.
- Throughput: one conversion per WIDTH+3 cycles.
  - start while in SHIFT or DONE is ignored and not queued.
  - start held high continuously re-launches on the first IDLE cycle.
- x is don't-care except on the accepting edge. Changing x during SHIFT must not affect y.
- y changes only on the DONE transition or on reset. It is never observed partially updated.
- The final carry out of the MSB is discarded.

Test Plan:
- Defaults (W=4,+3,-2), x=0 -> done after 5 edges, y=3 (5'b00011). Then x=7 -> y=10 (5'b01010).
- Negative edge values: x=-1 -> y=-3 (5'b11101); x=-8 -> y=-10 (5'b10110). busy high for exactly 6 cycles per conversion.
- Exhaustive x=-8..7, back-to-back with start held high: every y matches the behavioural model (x>=0 ? x+3 : x-2). Consecutive done pulses are exactly 7 cycles apart.
- Pulse start with x=5, then change x to -6 and pulse start again during SHIFT -> a single done with y=8. The second start is ignored and no extra done occurs.
- Assert rst on the 3rd SHIFT edge of x=-4 -> busy=0, done=0, y=0 the next cycle, and no done afterwards. start and rst high together in IDLE -> remains IDLE.
- WIDTH=8, POS_OFF=128, NEG_OFF=128: x=127 -> y=255; x=-128 -> y=-256 (9'b100000000); x=0 -> y=128. done 9 edges after accept.
